spi_sync_filter: RTL

SPI_SYNC_FILTER -- requirements
Module: spi_sync_filter

---
 rtl/spi_sync_filter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/spi_sync_filter.sv
// SPI pin front end: per-pin synchronizer chains and glitch filters, followed by
// SCK/CS edge detection, CPOL/CPHA strobe selection and a per-word bit counter.
module spi_sync_filter #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_LEN    = 3,
  parameter bit          CPOL          = 1'b0,
  parameter bit          CPHA          = 1'b0,
  parameter bit          CS_ACTIVE_LOW = 1'b1,
  parameter int unsigned WORD_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sck,
  input  logic                          sdi,
  input  logic                          cs,
  output logic                          sck_out,
  output logic                          sdi_out,
  output logic                          cs_out,
  output logic                          cs_active,
  output logic                          sck_rise,
  output logic                          sck_fall,
  output logic                          cs_start,
  output logic                          cs_end,
  output logic                          sample_strobe,
  output logic                          shift_strobe,
  output logic [$clog2(WORD_WIDTH)-1:0] bit_index,
  output logic                          word_done
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned IdxW = $clog2(WORD_WIDTH);
  // Channel order: [0] sck, [1] sdi, [2] cs. Idle levels used by reset.
  localparam logic [2:0]      Idle   = {CS_ACTIVE_LOW, 1'b0, CPOL};
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(WORD_WIDTH - 1);

  logic [2:0]             pins;
  logic [SYNC_STAGES-1:0] sync_q [3];
  logic [2:0]             synced;
  logic [2:0]             filt_q, filt_d;
  logic [CntW-1:0]        cnt_q [3];
  logic [CntW-1:0]        cnt_d [3];
  logic                   sck_prev_q, cs_prev_q;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic                   cs_prev_active;
  logic                   lead_edge, trail_edge, samp_edge, shft_edge;

  assign pins = {cs, sdi, sck};

  // Synchronizer chains, shifting in the raw pin at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < 3; ch++) sync_q[ch] <= {SYNC_STAGES{Idle[ch]}};
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], pins[ch]};
      end
    end
  end

  // Last chain stage is the synced value fed to each filter.
  always_comb begin
    synced = '0;
    for (int ch = 0; ch < 3; ch++) synced[ch] = sync_q[ch][SYNC_STAGES-1];
  end

  // Glitch filter: toggle only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    for (int ch = 0; ch < 3; ch++) begin
      cnt_d[ch] = '0;
      if (synced[ch] != filt_q[ch]) begin
        if (cnt_q[ch] == CntMax) begin
          filt_d[ch] = ~filt_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
  end

  // Filter state plus one-cycle-delayed copies of SCK and CS for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= Idle;
      sck_prev_q <= Idle[0];
      cs_prev_q  <= Idle[2];
      for (int ch = 0; ch < 3; ch++) cnt_q[ch] <= '0;
    end else begin
      filt_q     <= filt_d;
      sck_prev_q <= filt_q[0];
      cs_prev_q  <= filt_q[2];
      for (int ch = 0; ch < 3; ch++) cnt_q[ch] <= cnt_d[ch];
    end
  end

  // Edge pulses and strobe selection; a same-cycle CS deassertion already has
  // cs_active low, so it suppresses both strobes without extra logic.
  always_comb begin
    sck_out        = filt_q[0];
    sdi_out        = filt_q[1];
    cs_out         = filt_q[2];
    cs_active      = filt_q[2] ^ CS_ACTIVE_LOW;
    cs_prev_active = cs_prev_q ^ CS_ACTIVE_LOW;
    sck_rise       = filt_q[0] & ~sck_prev_q;
    sck_fall       = ~filt_q[0] & sck_prev_q;
    cs_start       = cs_active & ~cs_prev_active;
    cs_end         = ~cs_active & cs_prev_active;
    lead_edge      = CPOL ? sck_fall : sck_rise;
    trail_edge     = CPOL ? sck_rise : sck_fall;
    samp_edge      = CPHA ? trail_edge : lead_edge;
    shft_edge      = CPHA ? lead_edge : trail_edge;
    sample_strobe  = samp_edge & cs_active;
    shift_strobe   = shft_edge & cs_active;
    bit_index      = idx_q;
    word_done      = sample_strobe & (idx_q == IdxMax) & ~cs_start & ~cs_end;
  end

  // Bit counter: CS transitions restart the word ahead of any sample.
  always_comb begin
    idx_d = idx_q;
    if (cs_start || cs_end) begin
      idx_d = '0;
    end else if (sample_strobe) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  // Bit counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule
